// File: rtl/word_unpack_pkg.sv
// Shared encodings and default geometry for the word-to-byte unpack block.
package word_unpack_pkg;

    localparam int SRC_W     = 16;
    localparam int DST_W     = 8;
    localparam int SRC_DEPTH = 16;
    localparam int DST_DEPTH = 32;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_READ_WORD = 4'b0010,
        ST_WRITE_HI  = 4'b0100,
        ST_WRITE_LO  = 4'b1000
    } state_e;

endpackage

// File: rtl/ram_dp_async_read.sv
// Simple dual-port RAM: synchronous write, combinational read. Contents are not reset.
module ram_dp_async_read #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/word_unpack_ctrl.sv
// Unpack sequencer: reads one source word, then writes its upper and lower bytes.
module word_unpack_ctrl
    import word_unpack_pkg::*;
#(
    parameter int N_WORDS = 16,
    parameter int AW_W    = 4,
    parameter int AW_B    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_mode,
    input  logic [SRC_W-1:0]   src_rd_data,
    output logic [AW_W-1:0]    src_rd_addr,
    output logic               dst_we,
    output logic [AW_B-1:0]    dst_addr,
    output logic [DST_W-1:0]   dst_wdata,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [AW_W-1:0]    wptr_q, wptr_d;
    logic [SRC_W-1:0]   word_q, word_d;
    logic               done_q, done_d;
    logic               last_word;

    assign last_word = (wptr_q == AW_W'(N_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        wptr_d  = wptr_q;
        word_d  = word_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (op_mode) begin
                    state_d = ST_READ_WORD;
                    done_d  = 1'b0;
                end
            end
            ST_READ_WORD: begin
                word_d  = src_rd_data;
                state_d = ST_WRITE_HI;
            end
            ST_WRITE_HI: state_d = ST_WRITE_LO;
            ST_WRITE_LO: begin
                // wptr wraps explicitly so it never reaches unused addresses
                if (last_word) begin
                    wptr_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wptr_d  = wptr_q + AW_W'(1);
                    state_d = ST_READ_WORD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_rd_addr = '0;
        dst_we      = 1'b0;
        dst_addr    = '0;
        dst_wdata   = '0;
        case (state_q)
            ST_READ_WORD: src_rd_addr = wptr_q;
            ST_WRITE_HI: begin
                dst_we    = 1'b1;
                dst_addr  = {wptr_q, 1'b0};
                dst_wdata = word_q[15:8];
            end
            ST_WRITE_LO: begin
                dst_we    = 1'b1;
                dst_addr  = {wptr_q, 1'b1};
                dst_wdata = word_q[7:0];
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: rtl/word_unpack_fsm.sv
// Top level: host-loaded word RAM, unpack controller, host-readable byte RAM.
module word_unpack_fsm
    import word_unpack_pkg::*;
#(
    parameter int N_WORDS = 16,
    parameter int AW_W    = 4,
    parameter int AW_B    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      data_wr,
    input  logic             wr_en,
    input  logic [AW_W-1:0]  wr_add,
    input  logic             op_mode,
    input  logic [AW_B-1:0]  rd_add,
    output logic [7:0]       data_out,
    output logic             busy,
    output logic             done
);

    logic [AW_W-1:0]  src_rd_addr;
    logic [SRC_W-1:0] src_rd_data;
    logic             dst_we;
    logic [AW_B-1:0]  dst_addr;
    logic [DST_W-1:0] dst_wdata;

    ram_dp_async_read #(.WIDTH(SRC_W), .DEPTH(N_WORDS), .AW(AW_W)) u_src_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_add),
        .wr_data (data_wr),
        .rd_addr (src_rd_addr),
        .rd_data (src_rd_data)
    );

    word_unpack_ctrl #(.N_WORDS(N_WORDS), .AW_W(AW_W), .AW_B(AW_B)) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_mode     (op_mode),
        .src_rd_data (src_rd_data),
        .src_rd_addr (src_rd_addr),
        .dst_we      (dst_we),
        .dst_addr    (dst_addr),
        .dst_wdata   (dst_wdata),
        .busy        (busy),
        .done        (done)
    );

    ram_dp_async_read #(.WIDTH(DST_W), .DEPTH(2 * N_WORDS), .AW(AW_B)) u_dst_ram (
        .clk     (clk),
        .we      (dst_we),
        .wr_addr (dst_addr),
        .wr_data (dst_wdata),
        .rd_addr (rd_add),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_word_unpack_fsm.sv
// Randomized bench for word_unpack_fsm against a timeline-based reference model.
module tb_word_unpack_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_wr;
    logic        wr_en;
    logic [3:0]  wr_add;
    logic        op_mode;
    logic [4:0]  rd_add;
    logic [7:0]  data_out;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: m_t counts edges since the accepted start; word k is
    // sampled at edge 3k+1, its bytes land at edges 3k+2 and 3k+3.
    logic [15:0] m_src [16];
    logic [7:0]  m_dst [32];
    bit          m_dvalid [32];
    bit          m_busy, m_done;
    int          m_t;
    logic [15:0] m_cap;

    word_unpack_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_wr  (data_wr),
        .wr_en    (wr_en),
        .wr_add   (wr_add),
        .op_mode  (op_mode),
        .rd_add   (rd_add),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int k;
        if (!m_busy) begin
            if (op_mode) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_done = 1'b0;
            end
        end else begin
            m_t++;
            k = (m_t - 1) / 3;
            case (m_t % 3)
                1: m_cap = m_src[k];
                2: begin m_dst[2*k] = m_cap[15:8]; m_dvalid[2*k] = 1'b1; end
                default: begin
                    m_dst[2*k+1] = m_cap[7:0];
                    m_dvalid[2*k+1] = 1'b1;
                    if (m_t == 48) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            endcase
        end
        if (wr_en) m_src[wr_add] = data_wr;
    endtask

    task automatic cyc(input bit op, input bit we, input int wa, input logic [15:0] wd);
        op_mode = op;
        wr_en   = we;
        wr_add  = wa[3:0];
        data_wr = wd;
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        op_mode = 1'b0;
        wr_en   = 1'b0;
    endtask

    task automatic finish_run();
        int n;
        n = 0;
        while (m_busy && n < 70) begin
            cyc(0, 0, 0, 16'h0);
            n++;
        end
        if (m_busy) chk("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_model_bytes();
        for (int b = 0; b < 32; b++) begin
            rd_add = b[4:0];
            #1;
            if (m_dvalid[b]) chk("byte_model", {24'd0, data_out}, {24'd0, m_dst[b]});
        end
    endtask

    task automatic read_byte(input int a, input logic [7:0] exp);
        rd_add = a[4:0];
        #1;
        chk($sformatf("byte%0d", a), {24'd0, data_out}, {24'd0, exp});
    endtask

    initial begin
        int n, pulses, run_len, max_run;
        rst_n   = 1'b0;
        data_wr = '0;
        wr_en   = 1'b0;
        wr_add  = '0;
        op_mode = 1'b0;
        rd_add  = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_t     = 0;
        m_cap   = '0;
        for (int i = 0; i < 16; i++) m_src[i] = 'x;
        for (int i = 0; i < 32; i++) begin m_dst[i] = '0; m_dvalid[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Basic unpack with an explicit latency count
        for (int k = 0; k < 16; k++) cyc(0, 1, k, 16'hA000 + 16'(k));
        cyc(1, 0, 0, 16'h0);
        n = 0;
        while (!done && n < 60) begin
            cyc(0, 0, 0, 16'h0);
            n++;
        end
        chk("latency", n, 32'd48);
        finish_run();
        read_byte(0, 8'hA0);
        read_byte(1, 8'h00);
        read_byte(31, 8'h0F);
        check_model_bytes();

        // Start pulse while busy is ignored
        cyc(1, 0, 0, 16'h0);
        n = 0;
        while (!done && n < 60) begin
            cyc((n == 10) ? 1'b1 : 1'b0, 0, 0, 16'h0);
            n++;
        end
        chk("latency_ignore", n, 32'd48);
        repeat (3) cyc(0, 0, 0, 16'h0);
        chk("no_restart", {31'd0, busy}, 32'd0);
        chk("done_sticky", {31'd0, done}, 32'd1);

        // Writes during a pass: word 15 early (seen), word 0 late (not seen)
        cyc(1, 0, 0, 16'h0);
        for (int c = 1; c <= 48 && m_busy; c++) begin
            if (c == 5)       cyc(0, 1, 15, 16'hBEEF);
            else if (c == 20) cyc(0, 1, 0, 16'h5555);
            else              cyc(0, 0, 0, 16'h0);
        end
        finish_run();
        read_byte(30, 8'hBE);
        read_byte(31, 8'hEF);
        read_byte(0, 8'hA0);
        read_byte(1, 8'h00);
        check_model_bytes();

        // Back-to-back passes with op_mode held high
        pulses = 0; run_len = 0; max_run = 0;
        for (int c = 0; c < 150; c++) begin
            cyc(1, 0, 0, 16'h0);
            if (done) begin
                run_len++;
                if (run_len == 1) pulses++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        chk("b2b_pulses", pulses, 32'd3);
        chk("b2b_pulse_len", max_run, 32'd1);
        finish_run();
        check_model_bytes();

        // Randomized loads, starts and in-flight writes
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) cyc(0, 1, k, 16'($urandom));
            cyc(1, 0, 0, 16'h0);
            n = 0;
            while (m_busy && n < 70) begin
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 15)), 16'($urandom));
                n++;
            end
            if (m_busy) chk("rand_timeout", 32'd1, 32'd0);
            check_model_bytes();
        end

        // Reset mid-run, then reload and rerun from word 0
        cyc(1, 0, 0, 16'h0);
        for (int c = 0; c < 25; c++) cyc(0, 0, 0, 16'h0);
        rst_n = 1'b0;
        #2;
        m_busy = 1'b0;
        m_done = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) cyc(0, 1, k, 16'h1234);
        cyc(1, 0, 0, 16'h0);
        finish_run();
        chk("midrst_finish_done", {31'd0, done}, 32'd1);
        for (int b = 0; b < 32; b++) read_byte(b, (b % 2 == 0) ? 8'h12 : 8'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/word_unpack_fsm.md
Name: word_unpack_fsm

Overview:
- Reverse-direction data-transfer FSM. The host loads 16-bit words into a 16x16 source RAM; a start request then splits every word into two bytes and writes them to a 32x8 destination RAM.
- The host reads the destination RAM asynchronously by byte address.
- Both RAMs are instances of the codebase's ram_dp_async_read: synchronous write, combinational read.

Parameters:
- N_WORDS, 16, number of source words; destination depth is 2*N_WORDS.
- AW_W, 4, source word address width (log2 N_WORDS).
- AW_B, 5, destination byte address width (AW_W+1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_wr  input  16  host write data for the source RAM.
- wr_en  input  1  host write enable for the source RAM.
- wr_add  input  AW_W  host write address for the source RAM.
- op_mode  input  1  start request, sampled only in IDLE.
- rd_add  input  AW_B  host read address for the destination RAM.
- data_out  output  8  destination RAM byte at rd_add, combinational.
- busy  output  1  high when state is not IDLE.
- done  output  1  high after a full unpack completes; sticky.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, wptr=0, word_q=0, busy=0, done=0. RAM contents are not reset.
- One-hot states: IDLE, READ_WORD, WRITE_HI, WRITE_LO.
- IDLE: if op_mode=1, go to READ_WORD and clear done on the same edge. Otherwise stay in IDLE.
- READ_WORD:
  - Source read address = wptr.
  - word_q <= source data.
  - Next state WRITE_HI.
- WRITE_HI:
  - Destination we=1, address {wptr,1'b0}, data word_q[15:8].
  - Next state WRITE_LO.
- WRITE_LO:
  - Destination we=1, address {wptr,1'b1}, data word_q[7:0].
  - If wptr==N_WORDS-1: wptr<=0, done<=1, next state IDLE.
  - Else: wptr<=wptr+1, next state READ_WORD.
- Byte order is fixed: even byte address holds the word's upper byte; odd byte address holds the lower byte.
- Latency: 3 cycles per word. Full unpack takes 3*N_WORDS cycles, i.e. 48 cycles from the first READ_WORD to done=1.
- Destination we is high only in WRITE_HI and WRITE_LO. Source and destination addresses are driven to 0 in all other states.
- op_mode while busy=1 is ignored: no restart, done stays 0.
- Holding op_mode=1 through completion starts a new pass on the cycle after IDLE is re-entered.
- done stays 1 until the next accepted start or reset.
- Host writes to the source during busy are permitted. A word is consumed as it reads at its READ_WORD cycle. A write to word k landing on the READ_WORD edge for k is not seen by that read; the old word is used.
- Reset mid-operation: immediate return to IDLE, wptr=0, done=0. Destination bytes already written keep their values.
- Address arithmetic is unsigned. wptr wraps explicitly at N_WORDS-1 and never overflows into unused addresses.
- Illegal or unused state encodings go to IDLE.

Decomposition:
- Shared package holds:
  - state encodings IDLE=4'b0001, READ_WORD=4'b0010, WRITE_HI=4'b0100, WRITE_LO=4'b1000;
  - default widths (16/8) and depths (16/32).
- The RAMs are the existing ram_dp_async_read instances: source w=16,d=16; destination w=8,d=32.
- One natural sub-module: word_unpack_ctrl, holding the FSM, wptr and word_q. The top level contains only the two RAM instances and wiring.

Test Plan:
- Reset: assert rst_n=0 mid-run, then release → busy=0, done=0, state IDLE. The next start begins at word 0.
- Basic unpack:
  - Stimulus: load word k = 16'hA000+k for k=0..15; pulse op_mode for 1 cycle.
  - done rises exactly 48 cycles after the first READ_WORD.
  - Reads: rd_add=0 → 8'hA0, rd_add=1 → 8'h00, rd_add=31 → 8'h0F.
- Start ignored while busy: pulse op_mode at cycle 10 of a run → completion still at cycle 48, with no restart.
- Write during busy:
  - Overwrite word 15 with 16'hBEEF at cycle 5 → bytes 30/31 read 8'hBE/8'hEF.
  - Overwrite word 0 at cycle 20 → bytes 0/1 keep the old values.
- Back-to-back: hold op_mode=1 continuously → done pulses high for one cycle at the end of each pass; a second pass starts immediately and clears done.
- Reset mid-run: reset at cycle 25, reload all words as 16'h1234, start → all even bytes read 8'h12 and all odd bytes read 8'h34 after done.
